// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register with valid/ready handshake and a
// 2-entry skid buffer (main + skid), synchronous flush and a registered
// write-back mux (wb_wdata comes straight from a flop).
// Optional feature macro: MEM_WB_FWD_EN enables the MEM->ID forwarding taps.
// When it is undefined the fwd_* outputs are tied to 0 and no comparators exist.
module mem_wb_pipe #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic              mem_regwrite,
   input  logic              mem_memtoreg,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] mem_out,
   input  logic [RD_W-1:0]   mem_rd,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_regwrite,
   output logic              wb_memtoreg,
   output logic [DATA_W-1:0] wb_rdata,
   output logic [DATA_W-1:0] wb_out,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_wdata,
   input  logic [RD_W-1:0]   fwd_rs1,
   input  logic [RD_W-1:0]   fwd_rs2,
   output logic              fwd_hit1,
   output logic              fwd_hit2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2
);

   // One held entry; wdata is the write-back mux result, resolved on entry.
   typedef struct packed {
      logic              regwrite;
      logic              memtoreg;
      logic [DATA_W-1:0] rdata;
      logic [DATA_W-1:0] out;
      logic [DATA_W-1:0] wdata;
      logic [RD_W-1:0]   rd;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t state;
   entry_t main_q, skid_q, in_e;
   logic   ready_q, valid_q;
   logic   in_fire, out_fire;

   // Pack the incoming entry and resolve the write-back mux before storage.
   always_comb begin
      in_e          = '0;
      in_e.regwrite = mem_regwrite;
      in_e.memtoreg = mem_memtoreg;
      in_e.rdata    = mem_rdata;
      in_e.out      = mem_out;
      in_e.wdata    = mem_memtoreg ? mem_rdata : mem_out;
      in_e.rd       = mem_rd;
   end

   assign in_fire  = mem_valid & ready_q;
   assign out_fire = valid_q & wb_ready;

   // Occupancy FSM. ready_q/valid_q are flops updated alongside the state so
   // mem_ready has no combinational path from wb_ready or mem_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush) begin
         // Data flops keep stale contents; valid_q=0 masks wb_regwrite.
         state   <= EMPTY;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_q  <= in_e;
                  state   <= ONE;
                  valid_q <= 1'b1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_e;
               end else if (in_fire) begin
                  // Consumer stalled: park the new entry in the skid slot.
                  skid_q  <= in_e;
                  state   <= FULL;
                  ready_q <= 1'b0;
               end else if (out_fire) begin
                  state   <= EMPTY;
                  valid_q <= 1'b0;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_q  <= skid_q;
                  state   <= ONE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_ready   = ready_q;
   assign wb_valid    = valid_q;
   assign wb_regwrite = main_q.regwrite & valid_q;
   assign wb_memtoreg = main_q.memtoreg;
   assign wb_rdata    = main_q.rdata;
   assign wb_out      = main_q.out;
   assign wb_rd       = main_q.rd;
   assign wb_wdata    = main_q.wdata;

`ifdef MEM_WB_FWD_EN
   logic main_live, skid_live;
   logic m_hit1, m_hit2, s_hit1, s_hit2;

   assign main_live = valid_q & main_q.regwrite;
   assign skid_live = (state == FULL) & skid_q.regwrite;
   assign m_hit1    = main_live & (main_q.rd == fwd_rs1);
   assign m_hit2    = main_live & (main_q.rd == fwd_rs2);
   assign s_hit1    = skid_live & (skid_q.rd == fwd_rs1);
   assign s_hit2    = skid_live & (skid_q.rd == fwd_rs2);

   // Skid holds the younger write, so it wins over main on a double match.
   always_comb begin
      fwd_hit1  = s_hit1 | m_hit1;
      fwd_hit2  = s_hit2 | m_hit2;
      fwd_data1 = '0;
      fwd_data2 = '0;
      if (s_hit1)      fwd_data1 = skid_q.wdata;
      else if (m_hit1) fwd_data1 = main_q.wdata;
      if (s_hit2)      fwd_data2 = skid_q.wdata;
      else if (m_hit2) fwd_data2 = main_q.wdata;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_rs1, fwd_rs2};
   assign fwd_hit1   = 1'b0;
   assign fwd_hit2   = 1'b0;
   assign fwd_data1  = '0;
   assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed + randomized stimulus against a queue-based
// reference model of the 2-slot MEM/WB buffer.
module tb_mem_wb_pipe;
   localparam int DATA_W = 32;
   localparam int RD_W   = 3;

   logic              clk = 0, rst_n = 0, flush = 0;
   logic              mem_valid = 0, mem_ready;
   logic              mem_regwrite = 0, mem_memtoreg = 0;
   logic [DATA_W-1:0] mem_rdata = '0, mem_out = '0;
   logic [RD_W-1:0]   mem_rd = '0;
   logic              wb_valid, wb_ready = 0, wb_regwrite, wb_memtoreg;
   logic [DATA_W-1:0] wb_rdata, wb_out, wb_wdata;
   logic [RD_W-1:0]   wb_rd;
   logic [RD_W-1:0]   fwd_rs1 = '0, fwd_rs2 = '0;
   logic              fwd_hit1, fwd_hit2;
   logic [DATA_W-1:0] fwd_data1, fwd_data2;

   mem_wb_pipe #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
      .mem_rdata(mem_rdata), .mem_out(mem_out), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_regwrite(wb_regwrite),
      .wb_memtoreg(wb_memtoreg), .wb_rdata(wb_rdata), .wb_out(wb_out),
      .wb_rd(wb_rd), .wb_wdata(wb_wdata),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        rw;
      bit        m2r;
      bit [31:0] rdata;
      bit [31:0] out;
      bit [2:0]  rd;
   } ent_t;

   ent_t q[$];   // q[0] = oldest (main), q[1] = younger (skid)
   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Newest write to rs wins; model value is whatever the register file would receive.
   task automatic fwd_exp(input bit [2:0] rs, output bit hit, output bit [31:0] d);
      hit = 0; d = 0;
`ifdef MEM_WB_FWD_EN
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (!hit && q[i].rw && q[i].rd == rs) begin
            hit = 1;
            d   = q[i].m2r ? q[i].rdata : q[i].out;
         end
      end
`endif
   endtask

   task automatic check_outputs();
      bit h; bit [31:0] d;
      chk("mem_ready", mem_ready, q.size() < 2);
      chk("wb_valid", wb_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("wb_regwrite", wb_regwrite, q[0].rw);
         chk("wb_memtoreg", wb_memtoreg, q[0].m2r);
         chk("wb_rdata", wb_rdata, q[0].rdata);
         chk("wb_out", wb_out, q[0].out);
         chk("wb_rd", wb_rd, q[0].rd);
         chk("wb_wdata", wb_wdata, q[0].m2r ? q[0].rdata : q[0].out);
      end else begin
         chk("wb_regwrite_empty", wb_regwrite, 0);
      end
      fwd_exp(fwd_rs1, h, d);
      chk("fwd_hit1", fwd_hit1, h);
      chk("fwd_data1", fwd_data1, d);
      fwd_exp(fwd_rs2, h, d);
      chk("fwd_hit2", fwd_hit2, h);
      chk("fwd_data2", fwd_data2, d);
   endtask

   task automatic check_reset_vals();
      chk("rst_mem_ready", mem_ready, 1);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_regwrite", wb_regwrite, 0);
      chk("rst_wb_memtoreg", wb_memtoreg, 0);
      chk("rst_wb_rdata", wb_rdata, 0);
      chk("rst_wb_out", wb_out, 0);
      chk("rst_wb_wdata", wb_wdata, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_fwd_hit1", fwd_hit1, 0);
      chk("rst_fwd_hit2", fwd_hit2, 0);
      chk("rst_fwd_data1", fwd_data1, 0);
      chk("rst_fwd_data2", fwd_data2, 0);
   endtask

   // Called at a negedge: drive one cycle of inputs, advance the model on the
   // rising edge, then check outputs at the following negedge.
   task automatic cyc(input bit v, input bit rw, input bit m2r,
                      input bit [31:0] rdat, input bit [31:0] o, input bit [2:0] rd,
                      input bit wbr, input bit fl, input bit [2:0] rs1, input bit [2:0] rs2);
      bit acc, rel;
      ent_t e;
      mem_valid = v; mem_regwrite = rw; mem_memtoreg = m2r;
      mem_rdata = rdat; mem_out = o; mem_rd = rd;
      wb_ready = wbr; flush = fl; fwd_rs1 = rs1; fwd_rs2 = rs2;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else begin
         acc = v && (q.size() < 2);
         rel = (q.size() > 0) && wbr;
         if (rel) void'(q.pop_front());
         if (acc) begin
            e.rw = rw; e.m2r = m2r; e.rdata = rdat; e.out = o; e.rd = rd;
            q.push_back(e);
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_reset_vals();
      rst_n = 1;
      @(negedge clk);
      check_outputs();

      // Streaming with wb_ready high
      cyc(1, 1, 0, 12, 23, 1, 1, 0, 1, 2);
      chk("stream_wdata0", wb_wdata, 23);
      chk("stream_rd0", wb_rd, 1);
      cyc(1, 1, 1, 22, 31, 0, 1, 0, 0, 1);
      chk("stream_wdata1", wb_wdata, 22);
      chk("stream_rd1", wb_rd, 0);
      chk("stream_rw1", wb_regwrite, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      // Backpressure: A, B accepted, C held by source, then drain in order
      cyc(1, 1, 0, 0, 32'hA, 2, 0, 0, 2, 3);
      cyc(1, 1, 0, 0, 32'hB, 3, 0, 0, 2, 3);
      chk("bp_ready_low", mem_ready, 0);
      cyc(1, 1, 0, 0, 32'hC, 4, 0, 0, 2, 3);
      cyc(1, 1, 0, 0, 32'hC, 4, 1, 0, 2, 3);
      chk("bp_main_b", wb_out, 32'hB);
      cyc(1, 1, 0, 0, 32'hC, 4, 1, 0, 2, 3);
      chk("bp_main_c", wb_out, 32'hC);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      // Forwarding: skid (younger) beats main for the same rd
      cyc(1, 1, 0, 0, 5, 3, 0, 0, 3, 4);
      cyc(1, 1, 0, 0, 9, 3, 0, 0, 3, 4);
`ifdef MEM_WB_FWD_EN
      chk("fwd_prio", fwd_data1, 9);
`else
      chk("fwd_off", fwd_hit1, 0);
`endif

      // Flush in FULL with a same-cycle input that must be dropped
      cyc(1, 1, 0, 0, 32'hDEAD, 5, 0, 1, 5, 3);
      chk("flush_valid", wb_valid, 0);
      chk("flush_rw", wb_regwrite, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      // Bubble passes through without regwrite or forwarding hit
      cyc(1, 0, 0, 7, 8, 6, 0, 0, 6, 6);
      chk("bubble_valid", wb_valid, 1);
      chk("bubble_rw", wb_regwrite, 0);
      chk("bubble_hit", fwd_hit1, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      // Asynchronous reset mid-stream while FULL
      cyc(1, 1, 1, 32'h11, 32'h22, 1, 0, 0, 1, 1);
      cyc(1, 1, 0, 32'h33, 32'h44, 1, 0, 0, 1, 1);
      #2 rst_n = 0;
      #1 check_reset_vals();
      q.delete();
      @(negedge clk);
      rst_n = 1;

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
             $urandom, $urandom, 3'($urandom),
             $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
             3'($urandom), 3'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline register with valid/ready flow control, a 2-entry skid buffer, synchronous flush and a registered write-back result mux. Sits between the memory stage and the register-file write port. It replaces the fixed-width, always-advancing MEM/WB latch so that write-back can stall without losing in-flight results. Optional MEM→ID forwarding taps expose the newest pending write for hazard bypass.

## Interface
Parameters:
- DATA_W, 32, width of memory read data, ALU result and write-back data
- RD_W, 3, destination register index width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush; discards all held entries
- mem_valid  in  1  MEM stage presents an entry
- mem_ready  out  1  block can accept an entry this cycle
- mem_regwrite, mem_memtoreg  in  1 each  control bits of the entry
- mem_rdata  in  DATA_W  memory read data
- mem_out  in  DATA_W  ALU result
- mem_rd  in  RD_W  destination register
- wb_valid  out  1  WB entry present
- wb_ready  in  1  register file consumes the WB entry
- wb_regwrite  out  1  main.regwrite & wb_valid
- wb_memtoreg  out  1  held control bit
- wb_rdata, wb_out  out  DATA_W  held data
- wb_rd  out  RD_W  held destination
- wb_wdata  out  DATA_W  memtoreg ? rdata : out, of main entry
- fwd_rs1, fwd_rs2  in  RD_W  source registers to check
- fwd_hit1, fwd_hit2  out  1  forwarding match per source
- fwd_data1, fwd_data2  out  DATA_W  forwarded value per source

## Operation
- Storage: main entry (drives wb_*) and skid entry; each holds regwrite, memtoreg, rdata, out, rd. Write-back mux computed on input and stored, so wb_wdata is a flop output.
- in_fire = mem_valid & mem_ready; out_fire = wb_valid & wb_ready.
- States: EMPTY (no entries), ONE (main only), FULL (main + skid).
- EMPTY: in_fire → ONE, main ← input.
- ONE: in_fire & out_fire → ONE, main ← input; in_fire & !out_fire → FULL, skid ← input; !in_fire & out_fire → EMPTY; else hold.
- FULL: out_fire → ONE, main ← skid; else hold. Input not accepted in FULL.
- mem_ready = (state != FULL); purely registered, no combinational path from wb_ready or mem_valid.
- wb_valid = (state != EMPTY).
- flush: highest priority; next state EMPTY; any same-cycle in_fire entry dropped; data flops may hold stale values but wb_regwrite is 0.
- Entries with regwrite=0 pass through normally (bubbles occupy a slot).
- Outputs/data held stable while wb_valid & !wb_ready.

## Timing
- Reset (rst_n low, async): state EMPTY, mem_ready=1, wb_valid=0, wb_regwrite=0, wb_memtoreg=0, wb_rdata/wb_out/wb_wdata=0, wb_rd=0, fwd_hit*=0, fwd_data*=0. Reset mid-operation discards all entries immediately.
- Latency: entry accepted on edge N appears on wb_* after edge N (visible cycle N+1).
- Throughput: one entry per cycle with wb_ready held high.
- After wb_ready deasserts, at most one more entry accepted (into skid); mem_ready low the following cycle.
- Skid drain: FULL with out_fire → skid promoted to main at that edge; mem_ready high next cycle.
- fwd_* outputs combinational from stored state and fwd_rs*.

## Configuration
- MEM_WB_FWD_EN defined: fwd_hitN = 1 if a valid entry has regwrite=1 and rd == fwd_rsN; skid (younger) entry takes priority over main; fwd_dataN = matching entry's stored write-back value, else 0.
- MEM_WB_FWD_EN undefined: fwd_hit1/2 and fwd_data1/2 tied to 0; no comparators synthesised; ports remain.

## Test plan
- Reset: rst_n=0 mid-stream with FULL state → all outputs reset values immediately, mem_ready=1, wb_valid=0.
- Streaming: wb_ready=1, send {regwrite=1, memtoreg=0, rdata=12, out=23, rd=1} then {1,1,22,31,0} → next cycles wb_wdata=23 rd=1, then wb_wdata=22 rd=0, wb_regwrite=1.
- Backpressure: wb_ready=0, send three entries A,B,C → A in main, B in skid, mem_ready=0, C held by source; wb_ready=1 → A, B, C delivered in order, none lost or duplicated.
- Flush: FULL state, flush=1 with mem_valid=1 → next cycle wb_valid=0, mem_ready=1, wb_regwrite=0; flushed-cycle input never appears.
- Bubble: regwrite=0 entry → wb_valid=1, wb_regwrite=0, no forwarding hit.
- Forwarding (MEM_WB_FWD_EN): main rd=3 out=5, skid rd=3 out=9, fwd_rs1=3 → fwd_hit1=1, fwd_data1=9; fwd_rs2=4 → fwd_hit2=0, fwd_data2=0; without macro both hits 0.
